mst_chn_arb: RTL and testbench

//  Round-robin channel scheduler for Master FIFO multi-channel mode.

---
 rtl/mst_arb_pkg.sv | 32 +++
 rtl/mst_rr_pick.sv | 16 +
 rtl/mst_chn_arb.sv | 129 ++++++++++++
 tb/tb_mst_chn_arb.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mst_arb_pkg.sv
// rtl/mst_arb_pkg.sv - shared types, constants and round-robin helper for the channel arbiter
package mst_arb_pkg;

    localparam int NCH = 4;
    localparam int CHW = 2;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        OFFER = 2'd1,
        BUSY  = 2'd2,
        TURN  = 2'd3
    } arb_state_t;

    // Returns {any, pick}: first set bit of cand searching last+1 .. last+NCH (mod NCH)
    function automatic logic [CHW:0] rr_first(input logic [NCH-1:0] cand,
                                              input logic [CHW-1:0] last);
        logic [CHW-1:0] idx;
        logic [CHW-1:0] pick;
        logic           found;
        found = 1'b0;
        pick  = '0;
        for (int i = 1; i <= NCH; i++) begin
            idx = last + CHW'(i);
            if (cand[idx] && !found) begin
                found = 1'b1;
                pick  = idx;
            end
        end
        return {found, pick};
    endfunction

endpackage

// File: rtl/mst_rr_pick.sv
// rtl/mst_rr_pick.sv - combinational round-robin pick over four channel candidates
module mst_rr_pick
    import mst_arb_pkg::*;
(
    input  logic [NCH-1:0] cand,
    input  logic [CHW-1:0] last,
    output logic           any,
    output logic [CHW-1:0] pick
);

    // Channel after the last served one wins, so no channel can starve another
    always_comb begin
        {any, pick} = rr_first(cand, last);
    end

endmodule

// File: rtl/mst_chn_arb.sv
// rtl/mst_chn_arb.sv - round-robin FT600 channel scheduler with beat quota and turnaround (optional MST_ARB_STAT_EN grant counters)
module mst_chn_arb
    import mst_arb_pkg::*;
#(
    parameter int QUOTA    = 256,
    parameter int CNT_W    = 9,
    parameter int TURN_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             mltcn,
    input  logic [3:0]       req_vld,
    input  logic [3:0]       ch_rdy,
    input  logic             gnt_ack,
    input  logic             beat,
    input  logic             xfer_end,
    output logic             gnt_vld,
    output logic [1:0]       gnt_chn,
    output logic             busy,
    output logic [CNT_W-1:0] beat_cnt,
    output logic             quota_hit
`ifdef MST_ARB_STAT_EN
    ,
    input  logic             stat_clr,
    output logic [63:0]      stat_gnt
`endif
);

    localparam logic [CNT_W-1:0] QUOTA_M1  = CNT_W'(QUOTA - 1);
    localparam logic [2:0]       TURN_LAST = 3'(TURN_CYC - 1);

    arb_state_t     state;
    logic [CHW-1:0] last_chn;
    logic [2:0]     turn_cnt;
    logic [NCH-1:0] cand;
    logic           pick_any;
    logic [CHW-1:0] pick_chn;
    logic           quota_beat;

    // In 245 mode only channel 0 is eligible
    assign cand       = req_vld & ch_rdy & (mltcn ? 4'hF : 4'h1);
    assign quota_beat = beat && (beat_cnt == QUOTA_M1);

    mst_rr_pick u_pick (
        .cand (cand),
        .last (last_chn),
        .any  (pick_any),
        .pick (pick_chn)
    );

    // Arbitration FSM: offer, hold until ack or withdrawal, count beats, then turnaround gap
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            gnt_vld   <= 1'b0;
            gnt_chn   <= '0;
            busy      <= 1'b0;
            beat_cnt  <= '0;
            quota_hit <= 1'b0;
            last_chn  <= CHW'(NCH - 1);
            turn_cnt  <= '0;
        end else begin
            quota_hit <= 1'b0;
            case (state)
                IDLE: begin
                    if (pick_any) begin
                        state   <= OFFER;
                        gnt_vld <= 1'b1;
                        gnt_chn <= pick_chn;
                    end
                end
                OFFER: begin
                    if (gnt_ack) begin
                        state    <= BUSY;
                        last_chn <= gnt_chn;
                        beat_cnt <= '0;
                        busy     <= 1'b1;
                        gnt_vld  <= 1'b0;
                    end else if (!cand[gnt_chn]) begin
                        state   <= IDLE;
                        gnt_vld <= 1'b0;
                    end
                end
                BUSY: begin
                    if (beat) begin
                        beat_cnt <= beat_cnt + 1'b1;
                    end
                    if (quota_beat || xfer_end) begin
                        state     <= TURN;
                        busy      <= 1'b0;
                        turn_cnt  <= TURN_LAST;
                        quota_hit <= quota_beat;
                    end
                end
                TURN: begin
                    if (turn_cnt == 3'd0) begin
                        state <= IDLE;
                    end else begin
                        turn_cnt <= turn_cnt - 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

`ifdef MST_ARB_STAT_EN
    logic [NCH-1:0][15:0] stat_q;

    // Saturating per-channel grant counters; clear has priority over a same-cycle ack
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_q <= '0;
        end else begin
            for (int i = 0; i < NCH; i++) begin
                if (stat_clr) begin
                    stat_q[i] <= '0;
                end else if (state == OFFER && gnt_ack && gnt_chn == CHW'(i) &&
                             stat_q[i] != 16'hFFFF) begin
                    stat_q[i] <= stat_q[i] + 16'd1;
                end
            end
        end
    end

    assign stat_gnt = stat_q;
`endif

endmodule

// File: tb/tb_mst_chn_arb.sv
// tb/tb_mst_chn_arb.sv - self-checking bench for mst_chn_arb
module tb_mst_chn_arb;

    localparam int QUOTA    = 4;
    localparam int CNT_W    = 9;
    localparam int TURN_CYC = 1;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             mltcn;
    logic [3:0]       req_vld;
    logic [3:0]       ch_rdy;
    logic             gnt_ack;
    logic             beat;
    logic             xfer_end;
    logic             gnt_vld;
    logic [1:0]       gnt_chn;
    logic             busy;
    logic [CNT_W-1:0] beat_cnt;
    logic             quota_hit;
`ifdef MST_ARB_STAT_EN
    logic             stat_clr;
    logic [63:0]      stat_gnt;
`endif

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    mst_chn_arb #(.QUOTA(QUOTA), .CNT_W(CNT_W), .TURN_CYC(TURN_CYC)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mltcn     (mltcn),
        .req_vld   (req_vld),
        .ch_rdy    (ch_rdy),
        .gnt_ack   (gnt_ack),
        .beat      (beat),
        .xfer_end  (xfer_end),
        .gnt_vld   (gnt_vld),
        .gnt_chn   (gnt_chn),
        .busy      (busy),
        .beat_cnt  (beat_cnt),
        .quota_hit (quota_hit)
`ifdef MST_ARB_STAT_EN
        ,
        .stat_clr  (stat_clr),
        .stat_gnt  (stat_gnt)
`endif
    );

    typedef struct {
        logic       mltcn;
        logic [3:0] req;
        logic       ack;
        logic       beat;
        logic       xe;
        logic       gv;
        logic [1:0] ch;
        logic       busy;
        logic [8:0] cnt;
        logic       qh;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t v(logic m, logic [3:0] r, logic a, logic b, logic x,
                               logic gv, logic [1:0] ch, logic bs, logic [8:0] c, logic q);
        vec_t t;
        t.mltcn = m; t.req = r; t.ack = a; t.beat = b; t.xe = x;
        t.gv = gv; t.ch = ch; t.busy = bs; t.cnt = c; t.qh = q;
        return t;
    endfunction

    task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s got=%0h exp=%0h", nm, got, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [13:0] outs();
        return {gnt_vld, gnt_chn, busy, beat_cnt, quota_hit};
    endfunction

    // Reference model: offering / bursting flags, gap countdown, last served channel
    logic     m_gv, m_busy, m_qh;
    int       m_gap, m_last, m_chn, m_cnt;
    int       m_stat[4];

    task automatic model_reset();
        m_gv = 0; m_busy = 0; m_qh = 0; m_gap = 0; m_last = 3; m_chn = 0; m_cnt = 0;
        for (int i = 0; i < 4; i++) m_stat[i] = 0;
    endtask

    task automatic model_step();
        logic [3:0] cand;
        logic       found;
        if (!rst_n) begin
            model_reset();
            return;
        end
        cand = req_vld & ch_rdy & (mltcn ? 4'hF : 4'h1);
        m_qh = 0;
        if (m_busy) begin
            if (beat) begin
                m_cnt = m_cnt + 1;
                if (m_cnt == QUOTA) begin
                    m_qh = 1; m_busy = 0; m_gap = TURN_CYC;
                end
            end
            if (m_busy && xfer_end) begin
                m_busy = 0; m_gap = TURN_CYC;
            end
        end else if (m_gv) begin
            if (gnt_ack) begin
                m_gv = 0; m_busy = 1; m_last = m_chn; m_cnt = 0;
                if (m_stat[m_chn] < 65535) m_stat[m_chn]++;
            end else if (!cand[m_chn]) begin
                m_gv = 0;
            end
        end else if (m_gap > 0) begin
            m_gap--;
        end else begin
            found = 0;
            for (int k = 1; k <= 4; k++) begin
                if (!found && cand[(m_last + k) % 4]) begin
                    found = 1; m_chn = (m_last + k) % 4;
                end
            end
            if (found) m_gv = 1;
        end
`ifdef MST_ARB_STAT_EN
        if (stat_clr) for (int i = 0; i < 4; i++) m_stat[i] = 0;
`endif
    endtask

    initial begin
        logic [13:0] exp;
        rst_n = 0; mltcn = 1; req_vld = 0; ch_rdy = 4'hF;
        gnt_ack = 0; beat = 0; xfer_end = 0;
`ifdef MST_ARB_STAT_EN
        stat_clr = 0;
`endif
        tick(); tick();
        chk("rst_gnt_vld", 64'(gnt_vld), 64'd0);
        chk("rst_gnt_chn", 64'(gnt_chn), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_beat_cnt", 64'(beat_cnt), 64'd0);
        chk("rst_quota_hit", 64'(quota_hit), 64'd0);
`ifdef MST_ARB_STAT_EN
        chk("rst_stat_gnt", stat_gnt, 64'd0);
`endif
        rst_n = 1;

        //          mltcn req   ack beat xe  | gv ch busy cnt qh
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(1, 4'hF, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(1, 4'hF, 0, 1, 0, 0, 0, 1, 1, 0));
        tbl.push_back(v(1, 4'hF, 0, 1, 0, 0, 0, 1, 2, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 1, 0, 0, 0, 2, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 0, 0, 0, 2, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 1, 1, 0, 2, 0));
        tbl.push_back(v(1, 4'hF, 1, 0, 0, 0, 1, 1, 0, 0));
        tbl.push_back(v(1, 4'hF, 0, 1, 1, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 0, 1, 0, 1, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 1, 2, 0, 1, 0));
        tbl.push_back(v(1, 4'hB, 0, 0, 0, 0, 2, 0, 1, 0));
        tbl.push_back(v(1, 4'hF, 0, 0, 0, 1, 2, 0, 1, 0));
        tbl.push_back(v(1, 4'hB, 1, 0, 0, 0, 2, 1, 0, 0));
        tbl.push_back(v(1, 4'hB, 0, 1, 0, 0, 2, 1, 1, 0));
        tbl.push_back(v(1, 4'hB, 0, 1, 0, 0, 2, 1, 2, 0));
        tbl.push_back(v(1, 4'hB, 0, 1, 1, 0, 2, 0, 3, 0));
        tbl.push_back(v(1, 4'hB, 0, 0, 0, 0, 2, 0, 3, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 1, 0, 0, 3, 0));
        tbl.push_back(v(0, 4'hF, 1, 0, 0, 0, 0, 1, 0, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 1, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'hF, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'hF, 0, 1, 0, 1, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'hE, 0, 1, 0, 0, 0, 0, 0, 0));
        tbl.push_back(v(0, 4'hE, 0, 0, 0, 0, 0, 0, 0, 0));

        foreach (tbl[i]) begin
            mltcn = tbl[i].mltcn; req_vld = tbl[i].req; gnt_ack = tbl[i].ack;
            beat = tbl[i].beat; xfer_end = tbl[i].xe;
            tick();
            exp = {tbl[i].gv, tbl[i].ch, tbl[i].busy, tbl[i].cnt, tbl[i].qh};
            chk($sformatf("vec%0d", i), 64'(outs()), 64'(exp));
        end

        // Quota: continuous beats on ch2, pulse on 4th beat, one-cycle gap, then ch3
        mltcn = 1; req_vld = 4'h4; gnt_ack = 0; beat = 0; xfer_end = 0;
        tick(); chk("q_offer_ch2", 64'({gnt_vld, gnt_chn}), 64'({1'b1, 2'd2}));
        gnt_ack = 1; tick(); chk("q_busy", 64'(busy), 64'd1);
        gnt_ack = 0; beat = 1;
        tick(); tick(); tick();
        chk("q_cnt3", 64'({busy, beat_cnt, quota_hit}), 64'({1'b1, 9'd3, 1'b0}));
        tick();
        chk("q_hit", 64'({busy, beat_cnt, quota_hit}), 64'({1'b0, 9'd4, 1'b1}));
        req_vld = 4'hF;
        tick();
        chk("q_gap", 64'({gnt_vld, busy, beat_cnt, quota_hit}), 64'({1'b0, 1'b0, 9'd4, 1'b0}));
        beat = 0;
        tick(); chk("q_next_ch3", 64'({gnt_vld, gnt_chn}), 64'({1'b1, 2'd3}));

        // Async reset mid-burst
        gnt_ack = 1; tick(); chk("r_busy", 64'({busy, gnt_chn}), 64'({1'b1, 2'd3}));
        gnt_ack = 0; beat = 1; tick(); chk("r_cnt1", 64'(beat_cnt), 64'd1);
`ifdef MST_ARB_STAT_EN
        chk("stat_counts", stat_gnt, {16'd1, 16'd2, 16'd1, 16'd2});
`endif
        beat = 0;
        #2 rst_n = 0;
        #1;
        chk("r_async_outs", 64'(outs()), 64'd0);
`ifdef MST_ARB_STAT_EN
        chk("r_async_stat", stat_gnt, 64'd0);
`endif
        @(posedge clk); #1 rst_n = 1;
        tick(); chk("r_first_ch0", 64'({gnt_vld, gnt_chn}), 64'({1'b1, 2'd0}));

        // Randomized run against the reference model
        rst_n = 0; tick(); model_reset(); rst_n = 1;
        for (int c = 0; c < 3000; c++) begin
            rst_n    = ($urandom_range(0, 499) != 0);
            if ($urandom_range(0, 49) == 0) mltcn = ~mltcn;
            req_vld  = 4'($urandom);
            ch_rdy   = 4'($urandom) | 4'($urandom);
            gnt_ack  = ($urandom_range(0, 2) == 0);
            beat     = ($urandom_range(0, 3) != 0);
            xfer_end = ($urandom_range(0, 7) == 0);
`ifdef MST_ARB_STAT_EN
            stat_clr = ($urandom_range(0, 63) == 0);
`endif
            @(posedge clk);
            model_step();
            #1;
            exp = {m_gv, 2'(m_chn), m_busy, 9'(m_cnt), m_qh};
            chk($sformatf("rand%0d", c), 64'(outs()), 64'(exp));
`ifdef MST_ARB_STAT_EN
            chk($sformatf("rand_stat%0d", c), stat_gnt,
                {16'(m_stat[3]), 16'(m_stat[2]), 16'(m_stat[1]), 16'(m_stat[0])});
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
